// File: rtl/score_level_ctrl.sv
// -----------------------------------------------------------------------------
// score_level_ctrl
// Game progress controller for the pinball playfield. It keeps a four-digit
// BCD score, the current level, the remaining lives and the game state, and
// commands the ball back to its start position when a new ball is needed.
//
// Optional feature macro: LEVEL_BONUS_EN
//   When defined, every level-up adds 10*new_level and a win adds
//   10*MAX_LEVEL to the score, in the same cycle as the transition.
//   When undefined, no bonus logic is built.
//
// Ports
//   clk          in   system clock, all state on its rising edge
//   resetN       in   asynchronous active-low reset
//   startOfFrame in   one-cycle pulse per video frame (paces the LEVEL_UP pause)
//   start_key    in   level-sensitive start request
//   bumper_hit   in   one-cycle bumper collision pulse
//   target_hit   in   one-cycle target collision pulse
//   ball_lost    in   one-cycle pulse, ball left the bottom of the playfield
//   score_bcd    out  four BCD digits
//   level        out  current level, one BCD digit
//   lives        out  remaining lives
//   level_status out  00 IDLE, 01 PLAY/LEVEL_UP, 10 WIN, 11 GAME_OVER
//   ball_reset   out  one-cycle pulse, ball back to its initial position
// -----------------------------------------------------------------------------
module score_level_ctrl #(
  parameter int BUMPER_POINTS   = 1,
  parameter int TARGET_POINTS   = 5,
  parameter int LEVEL_UP_POINTS = 20,
  parameter int MAX_LEVEL       = 3,
  parameter int START_LIVES     = 3,
  parameter int PAUSE_FRAMES    = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        bumper_hit,
  input  logic        target_hit,
  input  logic        ball_lost,
  output logic [15:0] score_bcd,
  output logic [3:0]  level,
  output logic [1:0]  lives,
  output logic [1:0]  level_status,
  output logic        ball_reset
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_LEVEL_UP  = 3'd2,
    ST_WIN       = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [7:0]  BUMPER_C     = 8'(BUMPER_POINTS);
  localparam logic [7:0]  TARGET_C     = 8'(TARGET_POINTS);
  localparam logic [15:0] LUP_C        = 16'(LEVEL_UP_POINTS);
  localparam logic [3:0]  MAX_LVL_C    = 4'(MAX_LEVEL);
  localparam logic [1:0]  START_LIV_C  = 2'(START_LIVES);
  localparam logic [15:0] FRAME_LAST_C = 16'(PAUSE_FRAMES - 1);

  // Binary 0..99 to two BCD digits; only small per-cycle increments use it.
  function automatic logic [7:0] bin_to_bcd(input logic [7:0] b);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = b / 8'd10;
    ones = b % 8'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

  // Four-digit BCD plus two-digit BCD; a carry out of the top digit pins 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] bx;
    logic [15:0] r;
    logic [4:0]  s;
    logic        c;
    bx = {8'h00, b};
    r  = 16'h0000;
    c  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[i*4 +: 4]} + {1'b0, bx[i*4 +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        r[i*4 +: 4] = 4'(s - 5'd10);
        c           = 1'b1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        c           = 1'b0;
      end
    end
    if (c) begin
      r = 16'h9999;
    end else begin
      r = r;
    end
    return r;
  endfunction

  function automatic logic [1:0] status_of(input state_t st);
    logic [1:0] v;
    case (st)
      ST_IDLE:                v = 2'b00;
      ST_PLAY, ST_LEVEL_UP:   v = 2'b01;
      ST_WIN:                 v = 2'b10;
      ST_GAME_OVER:           v = 2'b11;
      default:                v = 2'b00;
    endcase
    return v;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] score_r, score_s;
  logic [3:0]  level_r, level_s;
  logic [1:0]  lives_r, lives_s;
  logic [1:0]  status_r, status_s;
  logic        ball_reset_r, ball_reset_s;
  logic [15:0] lvl_pts_r, lvl_pts_s;
  logic [15:0] frame_cnt_r, frame_cnt_s;
  logic [7:0]  hit_pts_s;
  logic [15:0] pts_sum_s;
  logic [15:0] score_hits_s;

  // Points earned this cycle; both hits together add their sum.
  assign hit_pts_s    = (bumper_hit ? BUMPER_C : 8'd0) + (target_hit ? TARGET_C : 8'd0);
  assign pts_sum_s    = lvl_pts_r + {8'd0, hit_pts_s};
  assign score_hits_s = bcd_add_sat(score_r, bin_to_bcd(hit_pts_s));

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_s      = state_r;
    score_s      = score_r;
    level_s      = level_r;
    lives_s      = lives_r;
    lvl_pts_s    = lvl_pts_r;
    frame_cnt_s  = frame_cnt_r;
    ball_reset_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_WIN, ST_GAME_OVER: begin
        if (start_key) begin
          state_s      = ST_PLAY;
          score_s      = 16'h0000;
          level_s      = 4'd1;
          lives_s      = START_LIV_C;
          lvl_pts_s    = 16'd0;
          frame_cnt_s  = 16'd0;
          ball_reset_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_PLAY: begin
        score_s   = score_hits_s;
        lvl_pts_s = pts_sum_s;
        // A threshold crossing outranks a lost ball in the same cycle.
        if (pts_sum_s >= LUP_C) begin
          if (level_r < MAX_LVL_C) begin
            state_s      = ST_LEVEL_UP;
            level_s      = level_r + 4'd1;
            lvl_pts_s    = 16'd0;
            frame_cnt_s  = 16'd0;
            ball_reset_s = 1'b1;
`ifdef LEVEL_BONUS_EN
            score_s      = bcd_add_sat(score_hits_s, {level_r + 4'd1, 4'd0});
`else
            score_s      = score_hits_s;
`endif
          end else begin
            state_s = ST_WIN;
`ifdef LEVEL_BONUS_EN
            score_s = bcd_add_sat(score_hits_s, {MAX_LVL_C, 4'd0});
`else
            score_s = score_hits_s;
`endif
          end
        end else if (ball_lost) begin
          // The last ball ends the game without recalling the ball.
          if (lives_r == 2'd1) begin
            lives_s = 2'd0;
            state_s = ST_GAME_OVER;
          end else begin
            lives_s      = lives_r - 2'd1;
            ball_reset_s = 1'b1;
          end
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_LEVEL_UP: begin
        if (startOfFrame) begin
          if (frame_cnt_r == FRAME_LAST_C) begin
            frame_cnt_s = 16'd0;
            state_s     = ST_PLAY;
          end else begin
            frame_cnt_s = frame_cnt_r + 16'd1;
          end
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    status_s = status_of(state_s);
  end

  // State and output registers; reset discards all game progress.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= ST_IDLE;
      score_r      <= 16'h0000;
      level_r      <= 4'd0;
      lives_r      <= 2'd0;
      status_r     <= 2'b00;
      ball_reset_r <= 1'b0;
      lvl_pts_r    <= 16'd0;
      frame_cnt_r  <= 16'd0;
    end else begin
      state_r      <= state_s;
      score_r      <= score_s;
      level_r      <= level_s;
      lives_r      <= lives_s;
      status_r     <= status_s;
      ball_reset_r <= ball_reset_s;
      lvl_pts_r    <= lvl_pts_s;
      frame_cnt_r  <= frame_cnt_s;
    end
  end

  assign score_bcd    = score_r;
  assign level        = level_r;
  assign lives        = lives_r;
  assign level_status = status_r;
  assign ball_reset   = ball_reset_r;

endmodule

// File: tb/tb_score_level_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_level_ctrl
// Scoreboard bench for score_level_ctrl. A behavioural game model predicts the
// outputs for every driven cycle and queues them; the entry is popped and
// compared one clock later. A second instance with large level threshold
// exercises score saturation at 9999.
// -----------------------------------------------------------------------------
module tb_score_level_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN = 1'b0;
  logic        sof = 1'b0, start_key = 1'b0, bumper_hit = 1'b0, target_hit = 1'b0, ball_lost = 1'b0;
  logic [15:0] score_bcd;
  logic [3:0]  level;
  logic [1:0]  lives, level_status;
  logic        ball_reset;

  logic        start2 = 1'b0, bump2 = 1'b0, tgt2 = 1'b0;
  logic        zero2 = 1'b0;
  logic [15:0] score2;
  logic [3:0]  level2;
  logic [1:0]  lives2, status2;
  logic        ball_reset2;

  score_level_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(start_key),
    .bumper_hit(bumper_hit), .target_hit(target_hit), .ball_lost(ball_lost),
    .score_bcd(score_bcd), .level(level), .lives(lives),
    .level_status(level_status), .ball_reset(ball_reset)
  );

  score_level_ctrl #(
    .BUMPER_POINTS(9), .TARGET_POINTS(5), .LEVEL_UP_POINTS(30000)
  ) dut_sat (
    .clk(clk), .resetN(resetN), .startOfFrame(zero2), .start_key(start2),
    .bumper_hit(bump2), .target_hit(tgt2), .ball_lost(zero2),
    .score_bcd(score2), .level(level2), .lives(lives2),
    .level_status(status2), .ball_reset(ball_reset2)
  );

  typedef struct packed {
    logic [15:0] score;
    logic [3:0]  level;
    logic [1:0]  lives;
    logic [1:0]  status;
    logic        br;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  string phase = "init";

  localparam int M_IDLE = 0, M_PLAY = 1, M_LU = 2, M_WIN = 3, M_GO = 4;
  int m_state, m_score, m_level, m_lives, m_pts, m_frames;
  logic m_br;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_score = 0; m_level = 0; m_lives = 0; m_pts = 0; m_frames = 0; m_br = 1'b0;
  endtask

  // Predict the outputs after one clock with the given inputs; queue them.
  task automatic model_step(input logic sk, input logic bh, input logic th, input logic bl, input logic sf);
    int add;
    exp_t e;
    logic [1:0] st;
    m_br = 1'b0;
    if (m_state == M_IDLE || m_state == M_WIN || m_state == M_GO) begin
      if (sk) begin
        m_state = M_PLAY; m_score = 0; m_level = 1; m_lives = 3; m_pts = 0; m_br = 1'b1;
      end
    end else if (m_state == M_PLAY) begin
      add = (bh ? 1 : 0) + (th ? 5 : 0);
      m_score = sat(m_score + add);
      m_pts = m_pts + add;
      if (m_pts >= 20) begin
        if (m_level < 3) begin
          m_level++; m_pts = 0; m_br = 1'b1; m_state = M_LU; m_frames = 0;
`ifdef LEVEL_BONUS_EN
          m_score = sat(m_score + 10 * m_level);
`endif
        end else begin
          m_state = M_WIN;
`ifdef LEVEL_BONUS_EN
          m_score = sat(m_score + 30);
`endif
        end
      end else if (bl) begin
        if (m_lives == 1) begin
          m_lives = 0; m_state = M_GO;
        end else begin
          m_lives--; m_br = 1'b1;
        end
      end
    end else if (m_state == M_LU) begin
      if (sf) begin
        m_frames++;
        if (m_frames == 60) begin
          m_state = M_PLAY; m_frames = 0;
        end
      end
    end
    case (m_state)
      M_IDLE:  st = 2'b00;
      M_WIN:   st = 2'b10;
      M_GO:    st = 2'b11;
      default: st = 2'b01;
    endcase
    e.score = to_bcd(m_score); e.level = 4'(m_level); e.lives = 2'(m_lives);
    e.status = st; e.br = m_br;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, then pop the prediction and compare.
  task automatic cycle(input logic sk, input logic bh, input logic th, input logic bl, input logic sf);
    exp_t e;
    start_key = sk; bumper_hit = bh; target_hit = th; ball_lost = bl; sof = sf;
    model_step(sk, bh, th, bl, sf);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_value("score", 32'(score_bcd), 32'(e.score));
    check_value("level", 32'(level), 32'(e.level));
    check_value("lives", 32'(lives), 32'(e.lives));
    check_value("status", 32'(level_status), 32'(e.status));
    check_value("ball_reset", 32'(ball_reset), 32'(e.br));
    start_key = 1'b0; bumper_hit = 1'b0; target_hit = 1'b0; ball_lost = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pause_frames();
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Assert reset between edges and check the asynchronous response at once.
  task automatic apply_reset();
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check_value("rst_score", 32'(score_bcd), 32'h0000);
    check_value("rst_level", 32'(level), 32'd0);
    check_value("rst_lives", 32'(lives), 32'd0);
    check_value("rst_status", 32'(level_status), 32'd0);
    check_value("rst_ball_reset", 32'(ball_reset), 32'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle2(input logic sk, input logic bh, input logic th);
    start2 = sk; bump2 = bh; tgt2 = th;
    @(posedge clk);
    #1;
    start2 = 1'b0; bump2 = 1'b0; tgt2 = 1'b0;
  endtask

  initial begin
    model_reset();
    phase = "reset";
    apply_reset();
    idle(2);

    phase = "start";
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("start_level", 32'(level), 32'd1);
    check_value("start_lives", 32'(lives), 32'd3);
    idle(1);

    phase = "levelup";
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef LEVEL_BONUS_EN
    check_value("lvl2_score", 32'(score_bcd), 32'h0040);
`else
    check_value("lvl2_score", 32'(score_bcd), 32'h0020);
`endif
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pause_frames();
    idle(1);

    phase = "lives";
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
    end
    check_value("go_status", 32'(level_status), 32'b11);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    phase = "both_hits";
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_value("sum_13", 32'(score_bcd), 32'h0013);

    phase = "win";
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pause_frames();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pause_frames();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_value("win_status", 32'(level_status), 32'b10);
    check_value("win_lives", 32'(lives), 32'd3);
    idle(2);

    phase = "reset_in_levelup";
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_reset();
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_value("fresh_level", 32'(level), 32'd1);
    check_value("fresh_score", 32'(score_bcd), 32'h0000);
    idle(1);

    phase = "saturate";
    cycle2(1'b1, 1'b0, 1'b0);
    check_value("sat_start_score", 32'(score2), 32'h0000);
    check_value("sat_start_level", 32'(level2), 32'd1);
    check_value("sat_start_lives", 32'(lives2), 32'd3);
    check_value("sat_start_br", 32'(ball_reset2), 32'd1);
    for (int i = 0; i < 1107; i++) cycle2(1'b0, 1'b1, 1'b0);
    check_value("sat_9963", 32'(score2), 32'h9963);
    for (int i = 0; i < 7; i++) cycle2(1'b0, 1'b0, 1'b1);
    check_value("sat_9998", 32'(score2), 32'h9998);
    check_value("sat_status", 32'(status2), 32'b01);
    cycle2(1'b0, 1'b0, 1'b1);
    check_value("sat_9999", 32'(score2), 32'h9999);
    cycle2(1'b0, 1'b1, 1'b1);
    check_value("sat_hold", 32'(score2), 32'h9999);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/score_level_ctrl.md
SCORE_LEVEL_CTRL -- requirements
Module: score_level_ctrl

Interface
REQ-001 SHALL have parameter BUMPER_POINTS, default 1, BCD points per bumper hit (0-9).
REQ-002 SHALL have parameter TARGET_POINTS, default 5, BCD points per target hit (0-9).
REQ-003 SHALL have parameter LEVEL_UP_POINTS, default 20, points within one level needed to advance.
REQ-004 SHALL have parameter MAX_LEVEL, default 3, last level; reaching its threshold wins the game.
REQ-005 SHALL have parameter START_LIVES, default 3, lives at game start (1-3).
REQ-006 SHALL have parameter PAUSE_FRAMES, default 60, frames held in LEVEL_UP before play resumes.
REQ-007 SHALL have port clk  input  1  system clock; one clock domain, all state on its rising edge.
REQ-008 SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-009 SHALL have port startOfFrame  input  1  one-cycle pulse per video frame.
REQ-010 SHALL have port start_key  input  1  level-sensitive start request.
REQ-011 SHALL have port bumper_hit  input  1  one-cycle bumper collision pulse.
REQ-012 SHALL have port target_hit  input  1  one-cycle target collision pulse.
REQ-013 SHALL have port ball_lost  input  1  one-cycle pulse, ball left the bottom of the playfield.
REQ-014 SHALL have port score_bcd  output  16  four BCD digits, drawn at the score position.
REQ-015 SHALL have port level  output  4  current level, one BCD digit, drawn at the level position.
REQ-016 SHALL have port lives  output  2  remaining lives.
REQ-017 SHALL have port level_status  output  2  00 IDLE, 01 PLAY/LEVEL_UP, 10 WIN, 11 GAME_OVER; drives the status display.
REQ-018 SHALL have port ball_reset  output  1  one-cycle pulse commanding the ball to return to its initial position (280,185).

Function
REQ-019 SHALL implement FSM states IDLE, PLAY, LEVEL_UP, WIN, GAME_OVER.
REQ-020 In IDLE, WIN or GAME_OVER, start_key high SHALL next cycle clear score to 0000, set level 1, lives START_LIVES, clear level points, pulse ball_reset, enter PLAY.
REQ-021 In PLAY, each cycle SHALL add BUMPER_POINTS*bumper_hit + TARGET_POINTS*target_hit to score in BCD, registered, 1-cycle latency; both hits in one cycle add the sum.
REQ-022 Score SHALL saturate at 9999; no wrap to 0000.
REQ-023 A binary level-points counter SHALL track points earned in the current level, updated in parallel with the score.
REQ-024 When level points reach >= LEVEL_UP_POINTS and level < MAX_LEVEL: level+1, level points cleared, ball_reset pulsed, enter LEVEL_UP.
REQ-025 When the threshold is reached at level == MAX_LEVEL: enter WIN, no ball_reset.
REQ-026 LEVEL_UP SHALL count startOfFrame pulses and return to PLAY on the PAUSE_FRAMES-th pulse.
REQ-027 In PLAY, ball_lost SHALL decrement lives and pulse ball_reset; if lives was 1, lives becomes 0 and the FSM enters GAME_OVER without ball_reset.
REQ-028 Threshold crossing and ball_lost in the same cycle: level-up/win takes priority; no life is lost.
REQ-029 Hits and ball_lost SHALL be ignored in all states other than PLAY.
REQ-030 ball_reset SHALL be exactly one cycle wide per triggering event.

Reset
REQ-031 On resetN low, immediately (asynchronously): state IDLE, score_bcd 0000, level 0, lives 0, level_status 00, ball_reset 0, frame and level-points counters 0.
REQ-032 Reset asserted mid-game or mid-LEVEL_UP SHALL discard all progress; no ball_reset pulse on release.

Configuration
REQ-033 With macro LEVEL_BONUS_EN defined, each level-up (REQ-024) and win (REQ-025) SHALL add a bonus of 10*new level (level-up) or 10*MAX_LEVEL (win) to the score, saturating, in the same cycle as the transition; bonus does not count toward level points.
REQ-034 Without LEVEL_BONUS_EN, no bonus logic SHALL exist and transitions leave the score unchanged.

Verification
REQ-035 Reset, then start_key -> score 0000, level 1, lives 3, status 01, one ball_reset pulse.
REQ-036 Four target hits (20 pts) -> score 0020, level 2, ball_reset pulse, LEVEL_UP; 60 startOfFrame pulses -> PLAY (with LEVEL_BONUS_EN: score 0040).
REQ-037 bumper_hit and target_hit in the same cycle at score 0007 -> score 0013 next cycle; score 9998 plus target -> 9999.
REQ-038 Three ball_lost pulses -> lives 2, 1, then GAME_OVER with status 11; third pulse gives no ball_reset; subsequent hits leave the score unchanged.
REQ-039 Level 3 at 19 level points, target_hit and ball_lost in the same cycle -> WIN, status 10, lives unchanged.
REQ-040 resetN low during LEVEL_UP -> all outputs at reset values; start_key afterwards -> fresh game at level 1.
